ld_cnt_bank: RTL and testbench

Parametrised bank of CHANNELS independent loadable up/down counter registers, each WIDTH bits wide. This is the next generation of the 16-bit load register. Each channel still supports hold and parallel load, and adds clear, increment, decrement, wrap or saturate arithmetic, and registered overflow/underflow event pulses. The block sits beside the processor datapath as the program-visible counter/timer resource; all channels update in the same clock cycle.

---
 rtl/ld_cnt_pkg.sv | 36 +++
 rtl/ld_cnt_chan.sv | 40 ++++
 rtl/ld_cnt_bank.sv | 35 +++
 tb/tb_ld_cnt_bank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ld_cnt_pkg.sv
// ld_cnt_pkg: command encoding and next-value arithmetic shared by the counter bank.
package ld_cnt_pkg;
  typedef enum logic [2:0] {
    CMD_HOLD = 3'd0,
    CMD_CLR  = 3'd1,
    CMD_LOAD = 3'd2,
    CMD_INC  = 3'd3,
    CMD_DEC  = 3'd4
  } cmd_t;

  typedef struct packed {
    logic [63:0] q;
    logic        ovf;
    logic        unf;
  } res_t;

  // Operands are zero-extended to 64 bits; the top bit of up/dn is the carry/borrow.
  function automatic res_t cnt_next(input logic [63:0] q, input logic [63:0] d, input cmd_t cmd,
                                    input logic [63:0] step, input logic sat, input int w);
    logic [64:0] top, up, dn;
    logic c, b;
    res_t r;
    top = (65'd1 << w) - 65'd1;
    up = {1'b0, q} + {1'b0, step};
    dn = {1'b0, q} - {1'b0, step};
    c = up > top;
    b = q < step;
    r.q = cmd == CMD_CLR  ? 64'd0 :
          cmd == CMD_LOAD ? d :
          cmd == CMD_INC  ? (c && sat ? top[63:0] : up[63:0] & top[63:0]) :
          cmd == CMD_DEC  ? (b && sat ? 64'd0 : dn[63:0] & top[63:0]) : q;
    r.ovf = cmd == CMD_INC && c;
    r.unf = cmd == CMD_DEC && b;
    return r;
  endfunction
endpackage

// File: rtl/ld_cnt_chan.sv
// ld_cnt_chan: one loadable up/down counter with registered overflow/underflow pulses.
module ld_cnt_chan
  import ld_cnt_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SATURATE = 0,
  parameter int STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             ovf,
  output logic             unf
);
  cmd_t cmd;
  res_t r;
  logic unused_hi;
  always_comb begin
    cmd = clr ? CMD_CLR : load ? CMD_LOAD : (inc ^ dec) ? (inc ? CMD_INC : CMD_DEC) : CMD_HOLD;
    r = cnt_next(64'(q), 64'(d), cmd, 64'(STEP), SATURATE != 0, WIDTH);
  end
  assign unused_hi = ^r.q;
  assign zero = q == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      q <= r.q[WIDTH-1:0];
      ovf <= r.ovf;
      unf <= r.unf;
    end
endmodule

// File: rtl/ld_cnt_bank.sv
// ld_cnt_bank: bank of independent loadable up/down counters updating on a common edge.
module ld_cnt_bank #(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0,
  parameter int STEP = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       zero,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       unf
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ld_cnt_chan #(.WIDTH(WIDTH), .SATURATE(SATURATE), .STEP(STEP)) u_chan (
      .clk(clk),
      .reset(reset),
      .clr(clr[i]),
      .load(load[i]),
      .inc(inc[i]),
      .dec(dec[i]),
      .d(d[i*WIDTH +: WIDTH]),
      .q(q[i*WIDTH +: WIDTH]),
      .zero(zero[i]),
      .ovf(ovf[i]),
      .unf(unf[i])
    );
  end
endmodule

// File: tb/tb_ld_cnt_bank.sv
// tb_ld_cnt_bank: directed checks of the default bank, a saturating bank and a narrow wrap bank.
module tb_ld_cnt_bank;
  logic clk = 0, reset = 1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  logic [3:0] clr0 = 0, load0 = 0, inc0 = 0, dec0 = 0, zero0, ovf0, unf0;
  logic [63:0] d0 = 0, q0;
  logic [0:0] clr1 = 0, load1 = 0, inc1 = 0, dec1 = 0, zero1, ovf1, unf1;
  logic [15:0] d1 = 0, q1;
  logic [0:0] clr2 = 0, load2 = 0, inc2 = 0, dec2 = 0, zero2, ovf2, unf2;
  logic [3:0] d2 = 0, q2;

  ld_cnt_bank u0 (.clk(clk), .reset(reset), .clr(clr0), .load(load0), .inc(inc0), .dec(dec0),
                  .d(d0), .q(q0), .zero(zero0), .ovf(ovf0), .unf(unf0));
  ld_cnt_bank #(.WIDTH(16), .CHANNELS(1), .SATURATE(1), .STEP(4)) u1 (
    .clk(clk), .reset(reset), .clr(clr1), .load(load1), .inc(inc1), .dec(dec1),
    .d(d1), .q(q1), .zero(zero1), .ovf(ovf1), .unf(unf1));
  ld_cnt_bank #(.WIDTH(4), .CHANNELS(1), .SATURATE(0), .STEP(3)) u2 (
    .clk(clk), .reset(reset), .clr(clr2), .load(load2), .inc(inc2), .dec(dec2),
    .d(d2), .q(q2), .zero(zero2), .ovf(ovf2), .unf(unf2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (q0 !== 64'd0 || zero0 !== 4'b1111 || ovf0 !== 4'd0 || unf0 !== 4'd0) begin
      errors++;
      $display("FAIL reset_init q=%h zero=%b ovf=%b unf=%b exp q=0 zero=1111 ovf=0 unf=0", q0, zero0, ovf0, unf0);
    end
    checks++;
    if (q1 !== 16'd0 || q2 !== 4'd0 || zero1 !== 1'b1 || zero2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_init_other q1=%h q2=%h exp 0", q1, q2);
    end
    reset = 0;
    step();
    load0 = 4'b0001; d0 = 64'h5;
    step();
    load0 = 0; inc0 = 4'b0001;
    step();
    checks++;
    if (q0[15:0] !== 16'h0006) begin
      errors++;
      $display("FAIL count_pre_reset q0=%h exp=0006", q0[15:0]);
    end
    #2 reset = 1;
    #1;
    checks++;
    if (q0 !== 64'd0 || zero0 !== 4'b1111 || ovf0 !== 4'd0 || unf0 !== 4'd0) begin
      errors++;
      $display("FAIL reset_async q=%h zero=%b ovf=%b unf=%b exp q=0 zero=1111", q0, zero0, ovf0, unf0);
    end
    inc0 = 0;
    #1 reset = 0;
    step();
    checks++;
    if (q0 !== 64'd0) begin
      errors++;
      $display("FAIL reset_release q=%h exp=0", q0);
    end
  endtask

  task automatic test_priority();
    load0 = 4'b0001; d0 = 64'h1234;
    step();
    checks++;
    if (q0[15:0] !== 16'h1234) begin
      errors++;
      $display("FAIL load q0=%h exp=1234", q0[15:0]);
    end
    clr0 = 4'b0001;
    step();
    checks++;
    if (q0[15:0] !== 16'h0000 || zero0[0] !== 1'b1) begin
      errors++;
      $display("FAIL clr_over_load q0=%h zero0=%b exp=0000 1", q0[15:0], zero0[0]);
    end
    clr0 = 0; load0 = 0; inc0 = 4'b0001; dec0 = 4'b0001;
    step();
    checks++;
    if (q0[15:0] !== 16'h0000 || ovf0[0] !== 1'b0 || unf0[0] !== 1'b0) begin
      errors++;
      $display("FAIL inc_dec_hold q0=%h ovf=%b unf=%b exp=0000 0 0", q0[15:0], ovf0[0], unf0[0]);
    end
    inc0 = 0; dec0 = 0;
  endtask

  task automatic test_wrap();
    logic [15:0] eq [3] = '{16'hFFFF, 16'h0000, 16'h0001};
    logic eo [3] = '{1'b0, 1'b1, 1'b0};
    load0 = 4'b0010; d0[31:16] = 16'hFFFE;
    step();
    load0 = 0; inc0 = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q0[31:16] !== eq[i] || ovf0[1] !== eo[i]) begin
        errors++;
        $display("FAIL wrap_inc[%0d] q1=%h ovf1=%b exp=%h %b", i, q0[31:16], ovf0[1], eq[i], eo[i]);
      end
    end
    inc0 = 0; load0 = 4'b0010; d0[31:16] = 16'h0000;
    step();
    checks++;
    if (ovf0[1] !== 1'b0 || q0[31:16] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_load q1=%h ovf1=%b exp=0000 0", q0[31:16], ovf0[1]);
    end
    load0 = 0; dec0 = 4'b0010;
    step();
    checks++;
    if (q0[31:16] !== 16'hFFFF || unf0[1] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_dec q1=%h unf1=%b exp=FFFF 1", q0[31:16], unf0[1]);
    end
    dec0 = 0;
    step();
    checks++;
    if (q0[31:16] !== 16'hFFFF || unf0[1] !== 1'b0) begin
      errors++;
      $display("FAIL unf_pulse q1=%h unf1=%b exp=FFFF 0", q0[31:16], unf0[1]);
    end
  endtask

  task automatic test_saturate();
    load1 = 1; d1 = 16'hFFFD;
    step();
    load1 = 0; inc1 = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (q1 !== 16'hFFFF || ovf1 !== 1'b1) begin
        errors++;
        $display("FAIL sat_inc[%0d] q=%h ovf=%b exp=FFFF 1", i, q1, ovf1);
      end
    end
    inc1 = 0; load1 = 1; d1 = 16'h0002;
    step();
    checks++;
    if (q1 !== 16'h0002 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL sat_load q=%h ovf=%b exp=0002 0", q1, ovf1);
    end
    load1 = 0; dec1 = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (q1 !== 16'h0000 || unf1 !== 1'b1 || zero1 !== 1'b1) begin
        errors++;
        $display("FAIL sat_dec[%0d] q=%h unf=%b exp=0000 1", i, q1, unf1);
      end
    end
    dec1 = 0;
  endtask

  task automatic test_independence();
    load0 = 4'b1111; d0 = {4{16'h0001}};
    step();
    load0 = 4'b0100; d0[47:32] = 16'hA5A5; inc0 = 4'b0001; dec0 = 4'b0010; clr0 = 4'b1000;
    step();
    checks++;
    if (q0 !== {16'h0000, 16'hA5A5, 16'h0000, 16'h0002}) begin
      errors++;
      $display("FAIL indep_q q=%h exp=0000a5a500000002", q0);
    end
    checks++;
    if (zero0 !== 4'b1010 || ovf0 !== 4'b0000 || unf0 !== 4'b0000) begin
      errors++;
      $display("FAIL indep_flags zero=%b ovf=%b unf=%b exp=1010 0000 0000", zero0, ovf0, unf0);
    end
    load0 = 0; inc0 = 0; dec0 = 0; clr0 = 0;
  endtask

  task automatic test_sweep();
    logic [3:0] eq [6] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2};
    clr2 = 1;
    step();
    clr2 = 0; inc2 = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (q2 !== eq[i] || ovf2 !== (i == 5) || unf2 !== 1'b0) begin
        errors++;
        $display("FAIL sweep[%0d] q=%0d ovf=%b unf=%b exp=%0d %b 0", i, q2, ovf2, unf2, eq[i], i == 5);
      end
    end
    inc2 = 0; dec2 = 1;
    step();
    checks++;
    if (q2 !== 4'd15 || unf2 !== 1'b1) begin
      errors++;
      $display("FAIL sweep_dec q=%0d unf=%b exp=15 1", q2, unf2);
    end
    dec2 = 0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_wrap();
    test_saturate();
    test_independence();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
